idu_stage: RTL and testbench
============================

Name: idu_stage

Overview:
- Registered, parametrised instruction-decode stage for the NPC core. Sits between IFU and EXU.
- Accepts one fetched 32-bit instruction per cycle over a valid/ready handshake.
- Extracts rd/rs1/rs2, builds the XLEN-wide sign/zero-extended immediate, and flags illegal opcodes.
- A 2-entry skid buffer gives full throughput under backpressure and a registered in_ready.

Parameters:
- XLEN, 32, datapath width (32 or 64); width of pc and imm; 64 also enables OP-IMM-32/OP-32 opcodes.
- CSR_RS2_ZERO, 1, when 1 force out_rs2=0 for beats tagged in_is_csr.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline flush (branch redirect / trap)
- in_valid  in  1  IFU beat valid
- in_ready  out  1  stage can accept a beat
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- in_is_csr  in  1  beat is a Zicsr instruction
- out_valid  out  1  decoded beat valid
- out_ready  in  1  EXU accepts beat
- out_inst  out  32  passthrough instruction
- out_pc  out  XLEN  passthrough pc
- out_rd  out  5  inst[11:7]
- out_rs1  out  5  inst[19:15]
- out_rs2  out  5  inst[24:20], or 0 if in_is_csr && CSR_RS2_ZERO
- out_imm  out  XLEN  extended immediate
- out_illegal  out  1  unsupported opcode, or inst[1:0] != 2'b11

Behaviour:
- Decode is combinational on the input side and captured at accept. Latency: a beat accepted at edge N appears on the outputs after edge N.
- Immediate by opcode inst[6:0]. All sign extension is from inst[31] to XLEN.
  - 0110111/0010111 (U): {inst[31:12],12'b0}, sign-extended.
  - 1101111 (J): {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - 1100011 (B): {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - 0100011 (S): {inst[31:25],inst[11:7]}.
  - 1100111/0000011/0010011 (I), and 0011011 when XLEN=64: inst[31:20].
  - 1110011 (SYSTEM): inst[31:20] zero-extended.
  - 0110011, 0001111, 0111011 (XLEN=64): imm=0.
  - Any other opcode: imm=0, out_illegal=1.
- Skid buffer: main slot M (drives outputs) and skid slot S.
  - in_ready = !S_valid && !rst.
  - out_valid = M_valid.
  - accept = in_valid && in_ready; pop = out_valid && out_ready.
- State transitions:
  - EMPTY + accept → M loaded (ONE).
  - ONE + accept + pop → M replaced (ONE).
  - ONE + accept, no pop → S loaded (TWO).
  - ONE + pop, no accept → EMPTY.
  - TWO: no accept possible; pop → M<=S, S cleared (ONE).
- Program order is always preserved.
- All out_* fields stay stable while out_valid && !out_ready.
- Flush: next edge clears M_valid and S_valid. Flush has priority over a simultaneous accept or pop; the accepted beat is dropped. Data registers are not required to clear.
- Reset: M_valid=S_valid=0, all data registers 0, all outputs 0; in_ready=0 while rst is high and 1 the cycle after.
- Reset asserted mid-transfer discards all buffered beats.
- rs1/rd are extracted for every opcode; consumers qualify them by opcode.

Test Plan:
- XLEN=32, in_inst=0xFFF10093 (addi x1,x2,-1) → next cycle out_valid=1, rd=1, rs1=2, rs2=31, imm=0xFFFFFFFF, illegal=0.
- XLEN=64, in_inst=0x800002B7 (lui x5,0x80000) → imm=0xFFFFFFFF80000000, rd=5.
- in_inst=0xFE000EE3 (beq x0,x0,-4) → imm=all-ones-minus-3 (0xFFFFFFFC for XLEN=32).
- in_inst=0xF1411073 with in_is_csr=1 → rs2=0, imm=0x00000F14 (zero-extended), rs1=2.
- in_inst=0x00000000 → out_illegal=1, imm=0.
- Backpressure:
  - Stimulus: out_ready=0, beats A,B,C offered back-to-back.
  - Required: A and B accepted, in_ready=0 after B; C held at input.
  - Then raise out_ready: outputs A,B,C on consecutive cycles, in_ready returns to 1 one cycle after A pops.
- Flush:
  - Stimulus: TWO state plus in_valid, flush=1 on the same edge.
  - Required: next cycle out_valid=0, in_ready=1, no stale beat emitted afterwards.
- Reset mid-stream:
  - Stimulus: rst=1 for one cycle.
  - Required: all outputs 0, then normal accept resumes.

Source files
------------

// File: rtl/idu_stage.sv
// Instruction decode stage: field extract, immediate build, illegal-opcode flag; one cycle accept-to-output.
// Two-slot skid buffer gives full throughput under out_ready backpressure; in_ready drops only when the skid slot is full.
module idu_stage #(
  parameter int XLEN         = 32,
  parameter bit CSR_RS2_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_is_csr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } beat_t;

  beat_t m_dat, s_dat, dec_dat;
  logic  m_vld, s_vld;
  logic  accept, pop;

  // Raw immediates held as signed so the XLEN cast sign-extends from inst[31].
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;
  logic signed [12:0] imm_b;
  logic signed [11:0] imm_s;
  logic signed [11:0] imm_i;

  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm_b = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_s = {in_inst[31:25], in_inst[11:7]};
  assign imm_i = in_inst[31:20];

  always_comb begin
    dec_dat      = '0;
    dec_dat.inst = in_inst;
    dec_dat.pc   = in_pc;
    dec_dat.rd   = in_inst[11:7];
    dec_dat.rs1  = in_inst[19:15];
    dec_dat.rs2  = (CSR_RS2_ZERO && in_is_csr) ? 5'd0 : in_inst[24:20];
    case (in_inst[6:0])
      7'b0110111, 7'b0010111:            dec_dat.imm = XLEN'(imm_u);
      7'b1101111:                        dec_dat.imm = XLEN'(imm_j);
      7'b1100011:                        dec_dat.imm = XLEN'(imm_b);
      7'b0100011:                        dec_dat.imm = XLEN'(imm_s);
      7'b1100111, 7'b0000011, 7'b0010011: dec_dat.imm = XLEN'(imm_i);
      7'b1110011:                        dec_dat.imm = XLEN'(in_inst[31:20]);
      7'b0110011, 7'b0001111:            dec_dat.imm = '0;
      7'b0011011: begin
        if (XLEN == 64) dec_dat.imm = XLEN'(imm_i);
        else            dec_dat.illegal = 1'b1;
      end
      7'b0111011: begin
        if (XLEN != 64) dec_dat.illegal = 1'b1;
      end
      default:                           dec_dat.illegal = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) dec_dat.illegal = 1'b1;
  end

  assign in_ready  = !s_vld && !rst;
  assign out_valid = m_vld;
  assign accept    = in_valid && in_ready;
  assign pop       = m_vld && out_ready;

  // Occupancy is EMPTY (!m), ONE (m && !s) or TWO (m && s); s never holds a beat without m.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_dat <= '0;
      s_dat <= '0;
    end else if (flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (s_vld) begin
      if (pop) begin
        m_dat <= s_dat;
        s_vld <= 1'b0;
      end
    end else if (m_vld) begin
      if (accept && pop) begin
        m_dat <= dec_dat;
      end else if (accept) begin
        s_dat <= dec_dat;
        s_vld <= 1'b1;
      end else if (pop) begin
        m_vld <= 1'b0;
      end
    end else if (accept) begin
      m_dat <= dec_dat;
      m_vld <= 1'b1;
    end
  end

  assign out_inst    = m_dat.inst;
  assign out_pc      = m_dat.pc;
  assign out_rd      = m_dat.rd;
  assign out_rs1     = m_dat.rs1;
  assign out_rs2     = m_dat.rs2;
  assign out_imm     = m_dat.imm;
  assign out_illegal = m_dat.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Bench for idu_stage: XLEN=32 and XLEN=64 instances share stimulus and are checked against a queue model every cycle.
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_is_csr, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        r32, v32, ill32;
  logic [31:0] inst32, pc32, imm32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic        r64, v64, ill64;
  logic [31:0] inst64;
  logic [63:0] pc64, imm64;
  logic [4:0]  rd64, rs1_64, rs2_64;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  always #5 clk = ~clk;

  idu_stage #(.XLEN(32), .CSR_RS2_ZERO(1'b1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .in_is_csr(in_is_csr),
    .out_valid(v32), .out_ready(out_ready), .out_inst(inst32), .out_pc(pc32),
    .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32), .out_imm(imm32), .out_illegal(ill32)
  );

  idu_stage #(.XLEN(64), .CSR_RS2_ZERO(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_inst(in_inst), .in_pc(in_pc), .in_is_csr(in_is_csr),
    .out_valid(v64), .out_ready(out_ready), .out_inst(inst64), .out_pc(pc64),
    .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64), .out_imm(imm64), .out_illegal(ill64)
  );

  typedef struct { logic [31:0] inst; logic [63:0] pc; logic csr; } raw_t;
  typedef struct { logic [4:0] rd, rs1, rs2; logic [63:0] imm; logic illegal; } dec_t;

  raw_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Immediates computed as signed integer values: field bits weighted by position, minus the sign-bit weight.
  function automatic dec_t model_dec(input logic [31:0] inst, input logic csr, input int xlen);
    dec_t   d;
    longint w, s, one;
    logic [6:0] op;
    w   = longint'({32'b0, inst});
    s   = longint'((w >> 31) & 1);
    one = 1;
    op  = 7'(w & 'h7F);
    d.rd      = 5'((w >> 7) & 31);
    d.rs1     = 5'((w >> 15) & 31);
    d.rs2     = csr ? 5'd0 : 5'((w >> 20) & 31);
    d.imm     = '0;
    d.illegal = 1'b0;
    case (op)
      7'h37, 7'h17: d.imm = (w & 'hFFFFF000) - s * (one << 32);
      7'h6F: d.imm = ((((w >> 21) & 'h3FF) << 1) | (((w >> 20) & 1) << 11) |
                      (((w >> 12) & 'hFF) << 12)) - s * (one << 20);
      7'h63: d.imm = ((((w >> 8) & 'hF) << 1) | (((w >> 25) & 'h3F) << 5) |
                      (((w >> 7) & 1) << 11)) - s * (one << 12);
      7'h23: d.imm = (((w >> 7) & 'h1F) | (((w >> 25) & 'h3F) << 5)) - s * (one << 11);
      7'h67, 7'h03, 7'h13: d.imm = ((w >> 20) & 'h7FF) - s * (one << 11);
      7'h1B: begin
        if (xlen == 64) d.imm = ((w >> 20) & 'h7FF) - s * (one << 11);
        else            d.illegal = 1'b1;
      end
      7'h73: d.imm = (w >> 20) & 'hFFF;
      7'h33, 7'h0F: d.imm = '0;
      7'h3B: if (xlen != 64) d.illegal = 1'b1;
      default: d.illegal = 1'b1;
    endcase
    if ((w & 3) != 3) d.illegal = 1'b1;
    if (xlen == 32) d.imm = d.imm & 64'hFFFF_FFFF;
    return d;
  endfunction

  // Model state: FIFO of accepted beats, capacity two, cleared by reset or flush.
  always @(posedge clk) begin
    if (run) begin
      if (rst || flush) begin
        q.delete();
      end else begin
        bit acc, pp;
        raw_t b;
        acc = in_valid && (q.size() < 2);
        pp  = (q.size() > 0) && out_ready;
        if (pp) void'(q.pop_front());
        if (acc) begin
          b.inst = in_inst; b.pc = in_pc; b.csr = in_is_csr;
          q.push_back(b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      int   n;
      dec_t e32, e64;
      n = q.size();
      chk("vld32", {63'b0, v32}, {63'b0, n != 0});
      chk("rdy32", {63'b0, r32}, {63'b0, (n < 2) && !rst});
      chk("vld64", {63'b0, v64}, {63'b0, n != 0});
      chk("rdy64", {63'b0, r64}, {63'b0, (n < 2) && !rst});
      if (n > 0) begin
        e32 = model_dec(q[0].inst, q[0].csr, 32);
        e64 = model_dec(q[0].inst, q[0].csr, 64);
        chk("inst32", {32'b0, inst32}, {32'b0, q[0].inst});
        chk("pc32",   {32'b0, pc32},   {32'b0, q[0].pc[31:0]});
        chk("rd32",   {59'b0, rd32},   {59'b0, e32.rd});
        chk("rs1_32", {59'b0, rs1_32}, {59'b0, e32.rs1});
        chk("rs2_32", {59'b0, rs2_32}, {59'b0, e32.rs2});
        chk("imm32",  {32'b0, imm32},  e32.imm);
        chk("ill32",  {63'b0, ill32},  {63'b0, e32.illegal});
        chk("inst64", {32'b0, inst64}, {32'b0, q[0].inst});
        chk("pc64",   pc64,            q[0].pc);
        chk("rs2_64", {59'b0, rs2_64}, {59'b0, e64.rs2});
        chk("imm64",  imm64,           e64.imm);
        chk("ill64",  {63'b0, ill64},  {63'b0, e64.illegal});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [63:0] pc, input logic csr);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; in_is_csr = csr;
    tick();
    in_valid = 1'b0; in_is_csr = 1'b0;
  endtask

  initial begin
    dec_t p;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_is_csr = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    run = 1'b1;

    // Hand-computed values pinning the model.
    p = model_dec(32'h0080006F, 1'b0, 32); chk("pin_jal", p.imm, 64'h8);
    p = model_dec(32'hFE112E23, 1'b0, 64); chk("pin_sw", p.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    p = model_dec(32'h0000001B, 1'b0, 32); chk("pin_w32", {63'b0, p.illegal}, 64'h1);

    tick(); tick();
    chk("rst_vld", {63'b0, v32}, 64'h0);
    chk("rst_rdy", {63'b0, r32}, 64'h0);
    chk("rst_imm", {32'b0, imm32}, 64'h0);
    rst = 1'b0;
    #1;
    chk("rst_rdy_after", {63'b0, r32}, 64'h1);
    out_ready = 1'b1;

    send(32'hFFF10093, 64'h8000_0000_0000_0100, 1'b0);
    chk("addi_vld", {63'b0, v32}, 64'h1);
    chk("addi_rd", {59'b0, rd32}, 64'd1);
    chk("addi_rs1", {59'b0, rs1_32}, 64'd2);
    chk("addi_rs2", {59'b0, rs2_32}, 64'd31);
    chk("addi_imm", {32'b0, imm32}, 64'hFFFF_FFFF);
    chk("addi_ill", {63'b0, ill32}, 64'h0);

    send(32'h800002B7, 64'h104, 1'b0);
    chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm32", {32'b0, imm32}, 64'h8000_0000);
    chk("lui_rd", {59'b0, rd64}, 64'd5);

    send(32'hFE000EE3, 64'h108, 1'b0);
    chk("beq_imm32", {32'b0, imm32}, 64'hFFFF_FFFC);
    chk("beq_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);

    send(32'hF1411073, 64'h10C, 1'b1);
    chk("csr_rs2", {59'b0, rs2_32}, 64'd0);
    chk("csr_imm", {32'b0, imm32}, 64'h0000_0F14);
    chk("csr_rs1", {59'b0, rs1_32}, 64'd2);

    send(32'h00000000, 64'h110, 1'b0);
    chk("zero_ill", {63'b0, ill32}, 64'h1);
    chk("zero_imm", {32'b0, imm32}, 64'h0);

    send(32'h0000001B, 64'h114, 1'b0);
    chk("addiw_ill32", {63'b0, ill32}, 64'h1);
    chk("addiw_ill64", {63'b0, ill64}, 64'h0);

    send(32'h00000011, 64'h118, 1'b0);
    send(32'hFE112E23, 64'h11C, 1'b0);
    send(32'h0080006F, 64'h120, 1'b0);
    send(32'h40B50533, 64'h124, 1'b0);
    send(32'h0000003B, 64'h128, 1'b0);
    tick();

    // Backpressure: A and B fill both slots, C waits at the input.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 64'h200;
    tick();
    in_inst = 32'h00200113; in_pc = 64'h204;
    tick();
    chk("bp_rdy_full", {63'b0, r32}, 64'h0);
    in_inst = 32'h00300193; in_pc = 64'h208;
    tick(); tick();
    chk("bp_hold_a", {32'b0, inst32}, 64'h00100093);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_before_pop", {63'b0, r32}, 64'h0);
    tick();
    chk("bp_out_b", {32'b0, inst32}, 64'h00200113);
    chk("bp_rdy_back", {63'b0, r32}, 64'h1);
    tick();
    in_valid = 1'b0;
    chk("bp_out_c", {32'b0, inst32}, 64'h00300193);
    tick();
    chk("bp_drained", {63'b0, v32}, 64'h0);

    // Flush while full with a beat on offer on the same edge.
    out_ready = 1'b0;
    send(32'h00400213, 64'h300, 1'b0);
    send(32'h00500293, 64'h304, 1'b0);
    in_valid = 1'b1; in_inst = 32'h00600313; in_pc = 64'h308; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld", {63'b0, v32}, 64'h0);
    chk("fl_rdy", {63'b0, r32}, 64'h1);
    out_ready = 1'b1;
    tick(); tick();
    chk("fl_no_stale", {63'b0, v64}, 64'h0);

    // Reset mid-stream with both slots occupied.
    out_ready = 1'b0;
    send(32'h00700393, 64'h400, 1'b0);
    send(32'h00800413, 64'h404, 1'b0);
    rst = 1'b1;
    tick();
    chk("mr_vld", {63'b0, v32}, 64'h0);
    chk("mr_inst", {32'b0, inst32}, 64'h0);
    chk("mr_imm", imm64, 64'h0);
    chk("mr_pc", pc64, 64'h0);
    chk("mr_rdy", {63'b0, r64}, 64'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h00900493, 64'h500, 1'b0);
    chk("mr_resume", {32'b0, inst32}, 64'h00900493);
    chk("mr_resume_imm", {32'b0, imm32}, 64'd9);
    tick(); tick();

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
